// File: rtl/tetris_pkg.sv
// Shared playfield constants and controller state encoding.
//   ROWS/COLS : default playfield geometry (row 0 is the top row)
//   COLOR_W   : cell colour width used by the cell array
//   LINES_W   : width of the per-pass cleared-line count
//   TOTAL_W   : width of the running cleared-line total
//   state_t   : line_clear_ctrl FSM state encoding
package tetris_pkg;

    localparam int unsigned ROWS    = 20;
    localparam int unsigned COLS    = 10;
    localparam int unsigned COLOR_W = 3;
    localparam int unsigned LINES_W = 3;
    localparam int unsigned TOTAL_W = 16;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_SCAN  = 3'd1;
    localparam state_t ST_EVAL  = 3'd2;
    localparam state_t ST_SHIFT = 3'd3;
    localparam state_t ST_DONE  = 3'd4;

endpackage

// File: rtl/row_priority_enc.sv
// Combinational priority encoder: index of the highest set bit of vec.
//   N       : vector width
//   vec     : input vector
//   idx_c   : index of the highest set bit (0 when nothing is set)
//   valid_c : at least one bit of vec is set
module row_priority_enc #(
    parameter int unsigned N = 20
) (
    input  logic [N-1:0]                       vec,
    output logic [(N > 1 ? $clog2(N) : 1)-1:0] idx_c,
    output logic                               valid_c
);

    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

    // Later (higher) indices overwrite earlier ones, so the highest set bit wins.
    always_comb begin
        idx_c   = '0;
        valid_c = 1'b0;
        for (int i = 0; i < int'(N); i++) begin
            if (vec[i]) begin
                idx_c   = IDX_W'(i);
                valid_c = 1'b1;
            end
        end
    end

endmodule

// File: rtl/line_clear_ctrl.sv
// Detects full playfield rows and collapses them bottom-up, one row per SHIFT,
// by strobing per-row advance enables into the cell array.
//   clk, reset    : clock, synchronous active-low reset
//   cell_occ      : cell occupancy, bit r*COLS+c
//   start         : request a clear pass (honoured only in IDLE)
//   busy          : pass in progress (SCAN through DONE)
//   done          : one-cycle pulse closing a pass
//   advance       : row r loads row r-1 (row 0 loads zero)
//   lines_cleared : rows removed by the last pass, saturating at 7
//   total_lines   : rows removed since reset, wrapping
module line_clear_ctrl
    import tetris_pkg::*;
#(
    parameter int unsigned ROWS = tetris_pkg::ROWS,
    parameter int unsigned COLS = tetris_pkg::COLS
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [ROWS*COLS-1:0]            cell_occ,
    input  logic                            start,
    output logic                            busy,
    output logic                            done,
    output logic [ROWS-1:0]                 advance,
    output logic [tetris_pkg::LINES_W-1:0]  lines_cleared,
    output logic [tetris_pkg::TOTAL_W-1:0]  total_lines
);

    localparam int unsigned IDX_W = (ROWS > 1) ? $clog2(ROWS) : 1;

    state_t               state_q, state_d;
    logic [ROWS-1:0]      full_q, full_d;
    logic [ROWS-1:0]      row_full;
    logic [IDX_W-1:0]     enc_idx;
    logic                 enc_valid;
    logic                 busy_d, done_d;
    logic [ROWS-1:0]      advance_d;
    logic [LINES_W-1:0]   lines_d;
    logic [TOTAL_W-1:0]   total_d;

    // Row-full reduction over the live occupancy.
    for (genvar r = 0; r < int'(ROWS); r++) begin : g_row_full
        assign row_full[r] = &cell_occ[r*COLS +: COLS];
    end

    // Bottom-most full row from the captured scan.
    row_priority_enc #(.N(ROWS)) u_enc (
        .vec     (full_q),
        .idx_c   (enc_idx),
        .valid_c (enc_valid)
    );

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            full_q        <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            advance       <= '0;
            lines_cleared <= '0;
            total_lines   <= '0;
        end else begin
            state_q       <= state_d;
            full_q        <= full_d;
            busy          <= busy_d;
            done          <= done_d;
            advance       <= advance_d;
            lines_cleared <= lines_d;
            total_lines   <= total_d;
        end
    end

    // Next-state and next-output logic; register inputs describe the following cycle.
    always_comb begin
        state_d   = state_q;
        full_d    = full_q;
        busy_d    = 1'b1;
        done_d    = 1'b0;
        advance_d = '0;
        lines_d   = lines_cleared;
        total_d   = total_lines;

        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    state_d = ST_SCAN;
                    busy_d  = 1'b1;
                    lines_d = '0;
                end
            end
            ST_SCAN: begin
                full_d  = row_full;
                state_d = ST_EVAL;
            end
            ST_EVAL: begin
                if (enc_valid) begin
                    state_d = ST_SHIFT;
                    // Thermometer: rows 0..k collapse, rows below k stay put.
                    for (int r = 0; r < int'(ROWS); r++) begin
                        advance_d[r] = (IDX_W'(r) <= enc_idx);
                    end
                end else begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end
            end
            ST_SHIFT: begin
                state_d = ST_SCAN;
                lines_d = (lines_cleared == '1) ? lines_cleared
                                                : lines_cleared + LINES_W'(1);
                total_d = total_lines + TOTAL_W'(1);
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

endmodule
